// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch-operand
// hazards, taken-branch/jump redirects, dmem wait freeze, timeout and stall accounting.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_reads_rs,
  input  logic             id_reads_rt,
  input  logic             id_branch,
  input  logic             id_equal,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_reg,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       pc_src,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  // state | meaning (action taken in the previous cycle)
  // RUN      | normal advance
  // STALL    | bubble inserted for a load-use / branch-operand hazard
  // REDIRECT | taken branch or jump, IF/ID flushed
  // WAIT     | whole pipe frozen on data memory
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_REDIRECT = 2'b10,
    ST_WAIT     = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               timeout_q, timeout_d;

  logic ex_match, mem_match, lu_haz, br_haz, mstall;

  // Register $0 never creates a dependency.
  assign ex_match  = (ex_write_reg != 5'd0) &&
                     ((id_reads_rs && ex_write_reg == id_rs) ||
                      (id_reads_rt && ex_write_reg == id_rt));
  assign mem_match = (mem_write_reg != 5'd0) &&
                     ((id_reads_rs && mem_write_reg == id_rs) ||
                      (id_reads_rt && mem_write_reg == id_rt));

  assign lu_haz = ex_mem_read && ex_match;
  assign br_haz = id_branch && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
  assign mstall = dmem_req && !dmem_ready;

  always_comb begin
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    pc_src      = 2'b00;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mstall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      state_d    = ST_WAIT;
    end else if (lu_haz || br_haz) begin
      // A hazard also masks a redirect: branch operands are not valid yet.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = ST_STALL;
    end else if (id_branch && id_equal) begin
      pc_src     = 2'b01;
      ifid_flush = 1'b1;
      state_d    = ST_REDIRECT;
    end else if (id_jump && !id_branch) begin
      pc_src     = 2'b10;
      ifid_flush = 1'b1;
      state_d    = ST_REDIRECT;
    end
  end

  // Wait counter parks at MEM_TIMEOUT; the flag is sticky so no wrap concerns.
  always_comb begin
    wait_d = '0;
    if (mstall) begin
      wait_d = (wait_q >= CNT_W'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
    end
    timeout_d = timeout_q || (wait_d == CNT_W'(MEM_TIMEOUT));
    stall_d   = (!pc_write && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors, a rule-level model compared every
// cycle at the falling edge, plus hand-computed pins at key points.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam int TMO   = 16;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_write_reg, mem_write_reg;
  logic id_reads_rs, id_reads_rt, id_branch, id_equal, id_jump;
  logic ex_mem_read, ex_reg_write, mem_mem_read, dmem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
  logic [1:0] pc_src, state;
  logic [CNT_W-1:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;
  bit done = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_reads_rs(id_reads_rs), .id_reads_rt(id_reads_rt),
    .id_branch(id_branch), .id_equal(id_equal), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .pc_src(pc_src),
    .state(state), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: previous action (0 run, 1 stall, 2 redirect, 3 wait), consecutive wait
  // count, sticky timeout, saturating stall count.
  int m_prev = 0, m_wait = 0, m_stall = 0;
  bit m_to = 0;
  int e_pcw, e_ifw, e_fl, e_bub, e_hold, e_src, act;
  bit em, mm, ms, lu, bh;

  always @(negedge clk) begin
    if (!done) begin
      em = ex_write_reg != 0 && ((id_reads_rs && ex_write_reg == id_rs) ||
                                 (id_reads_rt && ex_write_reg == id_rt));
      mm = mem_write_reg != 0 && ((id_reads_rs && mem_write_reg == id_rs) ||
                                  (id_reads_rt && mem_write_reg == id_rt));
      ms = dmem_req && !dmem_ready;
      lu = ex_mem_read && em;
      bh = id_branch && ((ex_reg_write && em) || (mem_mem_read && mm));
      if (rst) begin
        m_prev = 0; m_wait = 0; m_stall = 0; m_to = 0;
        {e_pcw, e_ifw, e_fl, e_bub, e_hold, e_src} = {32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0};
        act = 0;
      end else begin
        if (ms) act = 3;
        else if (lu || bh) act = 1;
        else if (id_branch && id_equal) act = 2;
        else if (id_jump) act = 2;
        else act = 0;
        e_pcw  = (act == 0 || act == 2) ? 1 : 0;
        e_ifw  = e_pcw;
        e_fl   = (act == 2) ? 1 : 0;
        e_bub  = (act == 1) ? 1 : 0;
        e_hold = (act == 3) ? 1 : 0;
        e_src  = (act != 2) ? 0 : (id_branch ? 1 : 2);
      end
      chk("pc_write", pc_write, e_pcw);
      chk("ifid_write", ifid_write, e_ifw);
      chk("ifid_flush", ifid_flush, e_fl);
      chk("idex_bubble", idex_bubble, e_bub);
      chk("pipe_hold", pipe_hold, e_hold);
      chk("pc_src", pc_src, e_src);
      chk("state", state, m_prev);
      chk("stall_cycles", stall_cycles, m_stall);
      chk("mem_timeout", mem_timeout, m_to);
      if (!rst) begin
        m_prev = act;
        m_wait = ms ? m_wait + 1 : 0;
        if (m_wait >= TMO) m_to = 1;
        if (e_pcw == 0 && m_stall < SAT) m_stall++;
      end
    end
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; id_reads_rs = 0; id_reads_rt = 0;
    id_branch = 0; id_equal = 0; id_jump = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    mem_mem_read = 0; mem_write_reg = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic lu_inputs();
    ex_mem_read = 1; ex_write_reg = 2; id_reads_rs = 1; id_rs = 2;
  endtask

  initial begin
    clr(); rst = 1;
    cyc(); cyc();
    rst = 0;

    at_neg(); chk("idle_pcw", pc_write, 1); chk("idle_stall", stall_cycles, 0); cyc();

    clr(); lu_inputs();
    at_neg(); chk("lu_pcw", pc_write, 0); chk("lu_ifidw", ifid_write, 0); chk("lu_bub", idex_bubble, 1); cyc();
    clr();
    at_neg(); chk("lu_state", state, 1); chk("lu_stall", stall_cycles, 1); chk("lu_after_pcw", pc_write, 1); cyc();

    clr(); ex_mem_read = 1; id_reads_rs = 1;
    at_neg(); chk("r0_pcw", pc_write, 1); cyc();
    clr();
    at_neg(); chk("r0_state", state, 0); cyc();

    clr(); id_branch = 1; id_reads_rs = 1; id_rs = 3; ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 3;
    at_neg(); chk("bl_bub1", idex_bubble, 1); cyc();
    clr(); id_branch = 1; id_reads_rs = 1; id_rs = 3; mem_mem_read = 1; mem_write_reg = 3;
    at_neg(); chk("bl_state1", state, 1); chk("bl_bub2", idex_bubble, 1); cyc();
    clr(); id_branch = 1; id_equal = 1; id_reads_rs = 1; id_rs = 3;
    at_neg(); chk("bl_state2", state, 1); chk("bl_pcsrc", pc_src, 1); chk("bl_flush", ifid_flush, 1);
    chk("bl_stall", stall_cycles, 3); cyc();
    clr();
    at_neg(); chk("bl_state3", state, 2); cyc();

    clr(); id_branch = 1; id_equal = 1; id_reads_rt = 1; id_rt = 5; ex_reg_write = 1; ex_write_reg = 5;
    at_neg(); chk("ba_pcsrc", pc_src, 0); chk("ba_bub", idex_bubble, 1); cyc();
    clr(); id_branch = 1; id_equal = 1; id_reads_rt = 1; id_rt = 5;
    at_neg(); chk("ba_redir", pc_src, 1); chk("ba_stall", stall_cycles, 4); cyc();

    clr(); id_jump = 1;
    at_neg(); chk("j_pcsrc", pc_src, 2); chk("j_flush", ifid_flush, 1); chk("j_pcw", pc_write, 1); cyc();
    clr();
    at_neg(); chk("j_state", state, 2); cyc();
    at_neg(); chk("j_state_run", state, 0); cyc();

    clr(); id_branch = 1; id_jump = 1; id_equal = 1;
    at_neg(); chk("bj_pcsrc", pc_src, 1); cyc();
    clr(); id_branch = 1;
    at_neg(); chk("bnt_pcsrc", pc_src, 0); chk("bnt_flush", ifid_flush, 0); cyc();

    clr(); dmem_req = 1; id_jump = 1;
    at_neg(); chk("mj_pcsrc", pc_src, 0); chk("mj_hold", pipe_hold, 1); chk("mj_flush", ifid_flush, 0); cyc();
    clr();
    at_neg(); chk("mj_state", state, 3); cyc();

    for (int i = 1; i <= 20; i++) begin
      clr(); lu_inputs(); dmem_req = 1;
      at_neg(); chk("to_hold", pipe_hold, 1); chk("to_bub", idex_bubble, 0);
      chk("to_flag", mem_timeout, (i >= 17) ? 1 : 0); cyc();
    end
    clr(); lu_inputs(); dmem_req = 1; dmem_ready = 1;
    at_neg(); chk("to_lu_bub", idex_bubble, 1); chk("to_lu_hold", pipe_hold, 0);
    chk("to_sticky", mem_timeout, 1); chk("to_state", state, 3); cyc();
    clr();
    at_neg(); chk("to_lu_state", state, 1); chk("to_sticky2", mem_timeout, 1); cyc();

    clr(); dmem_req = 1;
    repeat (260) cyc();
    at_neg(); chk("sat_stall", stall_cycles, SAT); cyc();

    clr(); dmem_req = 1;
    cyc();
    rst = 1;
    at_neg(); chk("rst_pcw", pc_write, 0); chk("rst_flush", ifid_flush, 1); chk("rst_bub", idex_bubble, 1);
    chk("rst_hold", pipe_hold, 0); chk("rst_state", state, 0); chk("rst_stall", stall_cycles, 0);
    chk("rst_to", mem_timeout, 0); cyc();
    rst = 0; clr();
    at_neg(); chk("post_state", state, 0); chk("post_stall", stall_cycles, 0); chk("post_to", mem_timeout, 0);
    chk("post_pcw", pc_write, 1); cyc();

    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Watches the ID-stage operands, the EX/MEM destination registers and the data-memory handshake.
- Drives PC write-enable, IF/ID write/flush, ID/EX bubble insertion, full-pipe freeze and PC source select.
- Keeps a small FSM plus counters for memory-wait timeout detection and stall accounting.

Parameters:
- MEM_TIMEOUT, 16, max consecutive dmem wait cycles before mem_timeout is raised.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  Rs field of instruction in ID.
- id_rt  in  5  Rt field of instruction in ID.
- id_reads_rs  in  1  ID instruction consumes Rs.
- id_reads_rt  in  1  ID instruction consumes Rt.
- id_branch  in  1  ID instruction is beq.
- id_equal  in  1  register-file compare result in ID.
- id_jump  in  1  ID instruction is j.
- ex_mem_read  in  1  instruction in EX is lw.
- ex_reg_write  in  1  instruction in EX writes a register.
- ex_write_reg  in  5  destination register of EX instruction.
- mem_mem_read  in  1  instruction in MEM is lw.
- mem_write_reg  in  5  destination register of MEM instruction.
- dmem_req  in  1  data memory access in progress this cycle.
- dmem_ready  in  1  data memory completes this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_bubble  out  1  zero the control signals entering ID/EX.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- pc_src  out  2  00 pc+4, 01 branch_address, 10 jump_address.
- state  out  2  FSM state: 00 RUN, 01 STALL, 10 REDIRECT, 11 WAIT.
- stall_cycles  out  CNT_W  saturating count of non-advancing cycles.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Term definitions (combinational):
  - m_rs = id_reads_rs && r == id_rs; m_rt = id_reads_rt && r == id_rt. A match requires r != 0.
  - lu_haz = ex_mem_read && match(ex_write_reg).
  - br_haz = id_branch && ((ex_reg_write && match(ex_write_reg)) || (mem_mem_read && match(mem_write_reg))).
  - mstall = dmem_req && !dmem_ready.
- Action priority, evaluated each cycle (outputs are combinational from inputs; FSM state is registered):
  - 1. mstall: pc_write=0, ifid_write=0, idex_bubble=0, pipe_hold=1, pc_src=00. Next state WAIT.
  - 2. lu_haz || br_haz: pc_write=0, ifid_write=0, idex_bubble=1, pipe_hold=0, pc_src=00. Next state STALL.
  - 3. id_branch && id_equal: pc_src=01, ifid_flush=1, pc_write=1. Next state REDIRECT.
  - 4. id_jump: pc_src=10, ifid_flush=1, pc_write=1. Next state REDIRECT.
  - 5. Otherwise: pc_write=1, ifid_write=1, all other outputs 0, pc_src=00. Next state RUN.
- Defaults: ifid_flush=0 except in cases 3 and 4; ifid_write=1 in cases 3 and 4.
- State meaning: state records the action taken in the previous cycle. STALL and REDIRECT last exactly one cycle unless the next cycle re-enters them.
- Resulting stall lengths:
  - Load-use costs 1 stall cycle.
  - beq depending on an ALU op in EX costs 1 stall cycle.
  - beq depending on a lw in EX costs 2 stall cycles: lu_haz, then br_haz from MEM.
  - A taken branch or jump costs 1 flushed slot.
- Simultaneous events:
  - mstall overrides everything; a redirect or stall request is re-evaluated once the memory completes.
  - A hazard suppresses a redirect, because branch operands are not yet valid.
  - id_branch and id_jump are never both 1; if they are, branch wins.
- Wait counter: an internal counter of CNT_W bits.
  - Increments each cycle in which mstall holds.
  - Clears on any cycle with !mstall.
  - When it reaches MEM_TIMEOUT, mem_timeout sets and stays 1 until rst.
  - Pipeline control is not altered by the timeout; the freeze continues.
- stall_cycles increments on every cycle with pc_write==0 and saturates at 2^CNT_W-1.
- Reset (rst=1, asynchronous):
  - state=RUN, counters=0, mem_timeout=0.
  - While rst is high, outputs are forced to: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0, pc_src=00.
  - Reset mid-WAIT or mid-STALL abandons the sequence; the first cycle after release is RUN.

Test Plan:
- lw $2 in EX (ex_mem_read=1, ex_write_reg=2), ID add reads rs=2 -> pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; state=01; stall_cycles=1.
- Same as above but ex_write_reg=0 -> no stall; pc_write=1, state stays 00.
- beq rs=3 in ID, lw $3 in EX, then in MEM -> 2 consecutive stall cycles; then id_equal=1 gives pc_src=01, ifid_flush=1; stall_cycles=2; state sequence 01,01,10.
- id_jump=1 with no hazards -> pc_src=10, ifid_flush=1, pc_write=1 for 1 cycle; next state 10, then 00.
- dmem_req=1, dmem_ready=0 for 20 cycles while lu_haz=1 -> pipe_hold=1, idex_bubble=0 throughout; mem_timeout rises after the 16th wait cycle and stays 1 after dmem_ready=1; the load-use stall is then taken.
- Assert rst during WAIT -> outputs go immediately to the reset values; after release, state=00, stall_cycles=0, mem_timeout=0.
